// File: rtl/game_ctrl_if.sv
// Pong match-sequencer signal bundle.
// master: the side that drives the start button and the ball-logic miss pulses.
// slave : the game_ctrl sequencer, which drives the registered control and score outputs.
interface game_ctrl_if;
    logic       start;
    logic       miss_p1;
    logic       miss_p2;
    logic       play_en;
    logic       ball_rst;
    logic       serve_dir;
    logic [3:0] score_p1;
    logic [3:0] score_p2;
    logic [1:0] winner;
    logic [2:0] state;

    modport master (
        output start, miss_p1, miss_p2,
        input  play_en, ball_rst, serve_dir, score_p1, score_p2, winner, state
    );

    modport slave (
        input  start, miss_p1, miss_p2,
        output play_en, ball_rst, serve_dir, score_p1, score_p2, winner, state
    );
endinterface

// File: rtl/game_ctrl.sv
// Pong match sequencer.
// Gates the paddle/ball datapath (play_en), recentres the ball between points
// (ball_rst), keeps both scores and latches the winner until a new start.
// Optional feature: define GAME_CTRL_PAUSE_EN to allow pausing PLAY with the
// start button. Without it there is no PAUSED state and encoding 5 never appears.
module game_ctrl #(
    parameter int unsigned CLK_HZ    = 10_000_000,
    parameter int unsigned PAUSE_MS  = 1000,
    parameter int unsigned WIN_SCORE = 7
) (
    input logic       clk,
    input logic       rst,
    game_ctrl_if.slave bus
);
    localparam int unsigned PAUSE_CYC = (CLK_HZ / 1000) * PAUSE_MS;
    localparam int unsigned CW        = $clog2(PAUSE_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(PAUSE_CYC - 1);
    localparam logic [3:0]    WIN      = 4'(WIN_SCORE);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SERVE  = 3'd1;
    localparam logic [2:0] S_PLAY   = 3'd2;
    localparam logic [2:0] S_POINT  = 3'd3;
    localparam logic [2:0] S_OVER   = 3'd4;
`ifdef GAME_CTRL_PAUSE_EN
    localparam logic [2:0] S_PAUSED = 3'd5;
`endif

    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_start_q;
    logic          r_play_en;
    logic          r_ball_rst;
    logic          r_serve_dir;
    logic [3:0]    r_score_p1;
    logic [3:0]    r_score_p2;
    logic [1:0]    r_winner;

    logic w_start_rise;
    logic w_pause_req;

    assign w_start_rise = bus.start & ~r_start_q;
`ifdef GAME_CTRL_PAUSE_EN
    assign w_pause_req  = w_start_rise;
`else
    assign w_pause_req  = 1'b0;
`endif

    // Match FSM: every output is a register updated alongside the state, so
    // play_en already reflects the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_start_q   <= 1'b0;
            r_play_en   <= 1'b0;
            r_ball_rst  <= 1'b0;
            r_serve_dir <= 1'b0;
            r_score_p1  <= '0;
            r_score_p2  <= '0;
            r_winner    <= 2'b00;
        end else begin
            r_start_q  <= bus.start;
            r_ball_rst <= 1'b0;
            case (r_state)
                S_IDLE, S_OVER: begin
                    r_play_en <= 1'b0;
                    if (w_start_rise) begin
                        r_score_p1 <= '0;
                        r_score_p2 <= '0;
                        r_winner   <= 2'b00;
                        r_ball_rst <= 1'b1;
                        r_cnt      <= '0;
                        r_state    <= S_SERVE;
                    end
                end
                S_SERVE: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt     <= '0;
                        r_play_en <= 1'b1;
                        r_state   <= S_PLAY;
                    end else begin
                        r_cnt     <= r_cnt + CW'(1);
                        r_play_en <= 1'b0;
                    end
                end
                S_PLAY: begin
                    // A pause request outranks a miss sampled in the same cycle.
                    if (w_pause_req) begin
                        r_play_en <= 1'b0;
`ifdef GAME_CTRL_PAUSE_EN
                        r_state   <= S_PAUSED;
`endif
                    end else if (bus.miss_p1 && bus.miss_p2) begin
                        r_play_en  <= 1'b0;
                        r_ball_rst <= 1'b1;
                        r_cnt      <= '0;
                        r_state    <= S_SERVE;
                    end else if (bus.miss_p1) begin
                        r_play_en   <= 1'b0;
                        r_score_p2  <= r_score_p2 + 4'd1;
                        r_serve_dir <= 1'b0;
                        r_state     <= S_POINT;
                    end else if (bus.miss_p2) begin
                        r_play_en   <= 1'b0;
                        r_score_p1  <= r_score_p1 + 4'd1;
                        r_serve_dir <= 1'b1;
                        r_state     <= S_POINT;
                    end else begin
                        r_play_en <= 1'b1;
                    end
                end
                S_POINT: begin
                    r_play_en <= 1'b0;
                    if (r_score_p1 == WIN) begin
                        r_winner <= 2'b01;
                        r_state  <= S_OVER;
                    end else if (r_score_p2 == WIN) begin
                        r_winner <= 2'b10;
                        r_state  <= S_OVER;
                    end else begin
                        r_ball_rst <= 1'b1;
                        r_cnt      <= '0;
                        r_state    <= S_SERVE;
                    end
                end
`ifdef GAME_CTRL_PAUSE_EN
                S_PAUSED: begin
                    if (w_start_rise) begin
                        r_play_en <= 1'b1;
                        r_state   <= S_PLAY;
                    end else begin
                        r_play_en <= 1'b0;
                    end
                end
`endif
                default: begin
                    r_play_en <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.play_en   = r_play_en;
    assign bus.ball_rst  = r_ball_rst;
    assign bus.serve_dir = r_serve_dir;
    assign bus.score_p1  = r_score_p1;
    assign bus.score_p2  = r_score_p2;
    assign bus.winner    = r_winner;
    assign bus.state     = r_state;
endmodule

// File: tb/tb_game_ctrl.sv
// Directed-vector bench for game_ctrl (PAUSE_CYC=4, WIN_SCORE=3).
module tb_game_ctrl;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    game_ctrl_if bus ();

    game_ctrl #(
        .CLK_HZ    (1000),
        .PAUSE_MS  (4),
        .WIN_SCORE (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sample and drive 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Called right after the ball_rst cycle: 3 more SERVE cycles, then PLAY.
    task automatic serve_to_play(input string tag);
        for (int i = 0; i < 3; i++) begin
            tick();
            check({tag, "_serve_state"}, bus.state, 1);
            check({tag, "_serve_play_en"}, bus.play_en, 0);
            check({tag, "_serve_ball_rst"}, bus.ball_rst, 0);
        end
        tick();
        check({tag, "_play_state"}, bus.state, 2);
        check({tag, "_play_en"}, bus.play_en, 1);
    endtask

    task automatic start_pulse();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic miss(input logic p1, input logic p2);
        bus.miss_p1 = p1;
        bus.miss_p2 = p2;
        tick();
        bus.miss_p1 = 1'b0;
        bus.miss_p2 = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.miss_p1 = 1'b0;
        bus.miss_p2 = 1'b0;

        // 1: reset then idle
        tick();
        tick();
        rst = 1'b0;
        check("rst_state", bus.state, 0);
        check("rst_play_en", bus.play_en, 0);
        check("rst_score_p1", bus.score_p1, 0);
        check("rst_score_p2", bus.score_p2, 0);
        check("rst_winner", bus.winner, 0);
        check("rst_serve_dir", bus.serve_dir, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_state", bus.state, 0);
            check("idle_ball_rst", bus.ball_rst, 0);
            check("idle_play_en", bus.play_en, 0);
        end

        // 2: start rise -> ball_rst pulse, 4 SERVE cycles, PLAY
        start_pulse();
        check("start_state", bus.state, 1);
        check("start_ball_rst", bus.ball_rst, 1);
        serve_to_play("t2");

        // 3: miss_p2 -> player 1 scores
        miss(1'b0, 1'b1);
        check("p2miss_state", bus.state, 3);
        check("p2miss_score_p1", bus.score_p1, 1);
        check("p2miss_score_p2", bus.score_p2, 0);
        check("p2miss_serve_dir", bus.serve_dir, 1);
        check("p2miss_play_en", bus.play_en, 0);
        tick();
        check("p2miss_reserve_state", bus.state, 1);
        check("p2miss_ball_rst", bus.ball_rst, 1);
        serve_to_play("t3");

        // 4: simultaneous misses -> no score, straight back to SERVE
        miss(1'b1, 1'b1);
        check("both_state", bus.state, 1);
        check("both_ball_rst", bus.ball_rst, 1);
        check("both_score_p1", bus.score_p1, 1);
        check("both_score_p2", bus.score_p2, 0);
        check("both_serve_dir", bus.serve_dir, 1);
        serve_to_play("t4");

        // 5: three miss_p1 -> player 2 wins
        for (int k = 1; k <= 3; k++) begin
            miss(1'b1, 1'b0);
            check("p1miss_state", bus.state, 3);
            check("p1miss_score_p2", bus.score_p2, k);
            check("p1miss_serve_dir", bus.serve_dir, 0);
            if (k < 3) begin
                tick();
                check("p1miss_ball_rst", bus.ball_rst, 1);
                serve_to_play("t5");
            end
        end
        tick();
        check("over_state", bus.state, 4);
        check("over_winner", bus.winner, 2);
        check("over_play_en", bus.play_en, 0);
        check("over_ball_rst", bus.ball_rst, 0);
        miss(1'b1, 1'b0);
        tick();
        check("over_miss_state", bus.state, 4);
        check("over_miss_score_p2", bus.score_p2, 3);
        check("over_miss_score_p1", bus.score_p1, 1);
        start_pulse();
        check("restart_state", bus.state, 1);
        check("restart_score_p1", bus.score_p1, 0);
        check("restart_score_p2", bus.score_p2, 0);
        check("restart_winner", bus.winner, 0);
        check("restart_ball_rst", bus.ball_rst, 1);
        serve_to_play("t5r");

        // 6a: reset mid-SERVE after a point
        miss(1'b0, 1'b1);
        check("pre_rst_score_p1", bus.score_p1, 1);
        tick();
        tick();
        check("mid_serve_state", bus.state, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_serve_state", bus.state, 0);
        check("rst_serve_score_p1", bus.score_p1, 0);
        check("rst_serve_serve_dir", bus.serve_dir, 0);
        check("rst_serve_play_en", bus.play_en, 0);
        check("rst_serve_ball_rst", bus.ball_rst, 0);

        // 6b: start in PLAY (pause or ignored), then reset mid-PLAY
        start_pulse();
        check("t6_start_ball_rst", bus.ball_rst, 1);
        serve_to_play("t6");
        start_pulse();
`ifdef GAME_CTRL_PAUSE_EN
        check("pause_state", bus.state, 5);
        check("pause_play_en", bus.play_en, 0);
        miss(1'b1, 1'b0);
        check("pause_miss_state", bus.state, 5);
        check("pause_miss_score_p2", bus.score_p2, 0);
        start_pulse();
        check("resume_state", bus.state, 2);
        check("resume_play_en", bus.play_en, 1);
`else
        check("play_start_state", bus.state, 2);
        check("play_start_play_en", bus.play_en, 1);
`endif
        miss(1'b1, 1'b0);
        check("t6_miss_score_p2", bus.score_p2, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_play_state", bus.state, 0);
        check("rst_play_play_en", bus.play_en, 0);
        check("rst_play_score_p2", bus.score_p2, 0);
        check("rst_play_winner", bus.winner, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
